// File: rtl/tlp_arb_pkg.sv
// Shared types and helpers for the TLP TX arbiter and its skid buffer.
//   arb_state_e : arbiter FSM states (IDLE while choosing an owner, BUSY while
//                 a packet is in flight).
//   beat_t      : one TLP beat {data, sop, eop} at the native 64-bit width.
//   rr_pick()   : round-robin selection returning a one-hot grant.
package tlp_arb_pkg;

  localparam int TLP_DATA_WIDTH = 64;
  localparam int MAX_REQ        = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TLP_DATA_WIDTH-1:0] data;
    logic                      sop;
    logic                      eop;
  } beat_t;

  // Scan valid[] starting one past rr_ptr, wrapping at num_req. The first
  // requester found wins. Returns all-zero when nobody is requesting.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         rr_ptr,
    input int unsigned        num_req
  );
    logic [MAX_REQ-1:0] pick;
    int unsigned        idx;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % num_req;
      if (k <= num_req && pick == '0 && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tlp_tx_arbiter_if.sv
// TLP beat stream: data plus SOP/EOP framing with a valid/ready handshake.
// A beat transfers on any clock edge where valid and ready are both high.
//   master : drives data/sop/eop/valid, observes ready.
//   slave  : observes data/sop/eop/valid, drives ready.
interface tlp_tx_arbiter_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;
  logic                  valid;
  logic                  ready;

  modport master (output data, sop, eop, valid, input ready);
  modport slave  (input data, sop, eop, valid, output ready);

endinterface

// File: rtl/tlp_skid_buffer.sv
// Two-entry skid buffer for a TLP beat stream. Both sides are registered:
// in_bus.ready depends only on occupancy, and out_bus is driven straight from
// the head register. The second entry catches the beat already in flight
// when the buffer fills, so upstream sees ready drop one cycle later without
// losing data. Reusable on the RX path.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_bus     : upstream beat stream (slave side)
//   out_bus    : downstream beat stream (master side)
module tlp_skid_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  tlp_tx_arbiter_if.slave    in_bus,
  tlp_tx_arbiter_if.master   out_bus
);

  localparam int ENTRY_W = DATA_WIDTH + 2;

  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic [1:0]         count_q;
  logic [ENTRY_W-1:0] in_entry;
  logic               push;
  logic               pop;

  assign in_entry      = {in_bus.data, in_bus.sop, in_bus.eop};
  assign in_bus.ready  = (count_q != 2'd2);
  assign out_bus.valid = (count_q != 2'd0);
  assign {out_bus.data, out_bus.sop, out_bus.eop} = head_q;

  assign push = in_bus.valid & in_bus.ready;
  assign pop  = out_bus.valid & out_bus.ready;

  // NOTE: the storage registers are reset as well as the count because the
  // head drives the outputs directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, which makes the head<=tail shift order-independent.
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= in_entry;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_entry;
          end else if (push) begin
            tail_q  <= in_entry;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          // Full: ready is low, so only a pop can happen here.
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Shares the single FPGA->Host TLP pipe between NUM_REQ sources with
// packet-atomic round-robin arbitration. A grant is taken in IDLE (one bubble
// cycle per packet) and held until the EOP beat is accepted. Output is
// registered through a 2-entry skid buffer.
//   pcieClk_in, pcieNRST_in  : clock, asynchronous active-low reset
//   req*_in / reqReady_out   : per-requester beat streams
//   tx*_out / txReady_in     : beat stream to the PCIe core
//   grant_out                : one-hot pipe owner, 0 while IDLE
//   protoErr_out             : sticky SOP framing error, cleared by reset
module tlp_tx_arbiter
  import tlp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                               pcieClk_in,
  input  logic                               pcieNRST_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] reqData_in,
  input  logic [NUM_REQ-1:0]                 reqSOP_in,
  input  logic [NUM_REQ-1:0]                 reqEOP_in,
  input  logic [NUM_REQ-1:0]                 reqValid_in,
  output logic [NUM_REQ-1:0]                 reqReady_out,
  output logic [DATA_WIDTH-1:0]              txData_out,
  output logic                               txSOP_out,
  output logic                               txEOP_out,
  output logic                               txValid_out,
  input  logic                               txReady_in,
  output logic [NUM_REQ-1:0]                 grant_out,
  output logic                               protoErr_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               first_q, first_d;   // no beat accepted yet in this grant
  logic               err_q, err_d;

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic [PTR_W-1:0]   win_idx;
  logic               accept;

  tlp_tx_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) arb_bus ();
  tlp_tx_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) tx_bus ();

  tlp_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk     (pcieClk_in),
    .rst_n   (pcieNRST_in),
    .in_bus  (arb_bus),
    .out_bus (tx_bus)
  );

  assign txData_out   = tx_bus.data;
  assign txSOP_out    = tx_bus.sop;
  assign txEOP_out    = tx_bus.eop;
  assign txValid_out  = tx_bus.valid;
  assign tx_bus.ready = txReady_in;

  // Forward the granted requester's beat. Grant is one-hot or zero.
  always_comb begin
    arb_bus.data  = '0;
    arb_bus.sop   = 1'b0;
    arb_bus.eop   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        arb_bus.data = reqData_in[i];
        arb_bus.sop  = reqSOP_in[i];
        arb_bus.eop  = reqEOP_in[i];
      end
    end
    arb_bus.valid = (state_q == BUSY) && ((grant_q & reqValid_in) != '0);
  end

  // Ready comes only from registers (state, grant, skid occupancy).
  assign reqReady_out = (state_q == BUSY && arb_bus.ready) ? grant_q : '0;
  assign accept       = arb_bus.valid & arb_bus.ready;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = reqValid_in;
    pick = rr_pick(valid_ext, 3'(rr_ptr_q), NUM_REQ);
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) win_idx = PTR_W'(i);
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    first_d  = first_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick != '0) begin
          state_d  = BUSY;
          grant_d  = pick[NUM_REQ-1:0];
          rr_ptr_d = win_idx;
          first_d  = 1'b1;
        end
      end
      BUSY: begin
        if (accept) begin
          first_d = 1'b0;
          // Opening beat must carry SOP; any later beat must not.
          if (first_q != arb_bus.sop) err_d = 1'b1;
          if (arb_bus.eop) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in or negedge pcieNRST_in) begin
    if (!pcieNRST_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  assign grant_out    = grant_q;
  assign protoErr_out = err_q;

endmodule
